// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundles the display-scan signals between the digit decoders, the scan
//   controller and the board pins.
//   Inputs to the controller:
//     en          scan enable, 0 forces the display dark
//     seg0..seg3  active-low segment patterns (g..a) for digits 0..3
//     dp_mask     bit d = 1 lights the decimal point of digit d
//   Outputs from the controller (all registered):
//     seg         active-low segment bus
//     an          active-low anode enables, an[d] selects digit d
//     dp          active-low decimal point
//     digit_sel   index of the digit owning the current slot
//     frame_tick  one-cycle pulse at the start of each completed frame
//   master: the side that drives patterns and enable (decoders / bench)
//   slave : the scan controller
interface seg_scan_if;
   logic       en;
   logic [6:0] seg0;
   logic [6:0] seg1;
   logic [6:0] seg2;
   logic [6:0] seg3;
   logic [3:0] dp_mask;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic [1:0] digit_sel;
   logic       frame_tick;

   modport master (
      output en, seg0, seg1, seg2, seg3, dp_mask,
      input  seg, an, dp, digit_sel, frame_tick
   );

   modport slave (
      input  en, seg0, seg1, seg2, seg3, dp_mask,
      output seg, an, dp, digit_sel, frame_tick
   );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexed scan controller for a four-digit common-anode
//   seven-segment display. Each digit owns a slot of DIV cycles. The first
//   BLANK cycles of a slot are dark (anti-ghosting gap), and the rest show
//   the digit's pattern, which is captured once at the start of the lit part.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg_scan_if.slave (enable, patterns, dp mask in; seg/an/dp,
//            digit_sel, frame_tick out)
//   Structure: a slot sequencer (cnt, digit index, BLANK/SHOW FSM) runs one
//   cycle ahead of a registered output stage. The output stage turns the
//   sequencer position into pins, so cycle k after reset release shows slot
//   position k mod DIV, and every output comes straight from a flop.
//   en=0 overrides the output stage directly, so darkness appears one
//   cycle after en is sampled low.

// Per-digit lane: decides whether this digit owns the current slot and
// contributes its (active-high) segment and dp bits to the shared mux.
module seg_scan_lane #(
   parameter logic [1:0] LANE = 2'd0
) (
   input  logic [1:0] dig,
   input  logic [6:0] pat_n,   // active-low pattern for this digit
   input  logic       dp_on,   // 1 lights this digit's dp
   output logic       hit,
   output logic [6:0] seg_on,  // active-high, zero when not selected
   output logic       dp_hit
);
   assign hit    = (dig == LANE);
   assign seg_on = hit ? ~pat_n : 7'h00;
   assign dp_hit = hit & dp_on;
endmodule

module seg_scan_controller #(
   parameter int DIV   = 100000,
   parameter int BLANK = 1000
) (
   input logic       clk,
   input logic       rst_n,
   seg_scan_if.slave bus
);
   localparam int            CW          = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BL_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] CNT_SHOW    = CW'(BLANK);
   localparam int            NUM_DIG     = 4;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   // ---------------- slot sequencer ----------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    dig_q, dig_d;
   // Set only on the step from digit 3's last SHOW cycle into digit 0's
   // first BLANK cycle, so it is never seen on the first frame after a
   // (re)start.
   logic          wrap_q, wrap_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         dig_q   <= 2'd0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      dig_d   = dig_q;
      wrap_d  = 1'b0;
      if (!bus.en) begin
         state_d = ST_BLANK;
         cnt_d   = '0;
         dig_d   = 2'd0;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (cnt_q == CNT_BL_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  dig_d   = dig_q + 2'd1;
                  wrap_d  = (dig_q == 2'd3);
               end
            end
            default: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // First lit cycle of the slot: the only point where the pattern is sampled.
   logic capture;
   assign capture = (state_q == ST_SHOW) && (cnt_q == CNT_SHOW);

   // ---------------- per-digit lanes ----------------
   logic [NUM_DIG-1:0][6:0] pat_n;
   logic [NUM_DIG-1:0][6:0] seg_on;
   logic [NUM_DIG-1:0]      hit;
   logic [NUM_DIG-1:0]      dp_hit;

   assign pat_n = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};

   for (genvar g = 0; g < NUM_DIG; g++) begin : g_lane
      seg_scan_lane #(.LANE(2'(g))) u_lane (
         .dig    (dig_q),
         .pat_n  (pat_n[g]),
         .dp_on  (bus.dp_mask[g]),
         .hit    (hit[g]),
         .seg_on (seg_on[g]),
         .dp_hit (dp_hit[g])
      );
   end

   // Exactly one lane hits, so OR-ing the gated lane outputs is the mux.
   logic [6:0] seg_pick_n;
   logic       dp_pick_n;
   always_comb begin
      logic [6:0] acc;
      acc = 7'h00;
      for (int i = 0; i < NUM_DIG; i++) acc = acc | seg_on[i];
      seg_pick_n = ~acc;
      dp_pick_n  = ~|dp_hit;
   end

   // ---------------- registered output stage ----------------
   logic [6:0] hold_seg;
   logic       hold_dp;
   logic [6:0] seg_q;
   logic [3:0] an_q;
   logic       dp_q;
   logic [1:0] sel_q;
   logic       tick_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_seg <= 7'h7F;
         hold_dp  <= 1'b1;
         seg_q    <= 7'h7F;
         an_q     <= 4'hF;
         dp_q     <= 1'b1;
         sel_q    <= 2'd0;
         tick_q   <= 1'b0;
      end else if (!bus.en) begin
         seg_q  <= 7'h7F;
         an_q   <= 4'hF;
         dp_q   <= 1'b1;
         sel_q  <= 2'd0;
         tick_q <= 1'b0;
      end else begin
         sel_q  <= dig_q;
         tick_q <= wrap_q;
         if (state_q == ST_BLANK) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
            dp_q  <= 1'b1;
         end else begin
            an_q <= ~hit;
            if (capture) begin
               // Pattern and dp are frozen here for the rest of the slot.
               hold_seg <= seg_pick_n;
               hold_dp  <= dp_pick_n;
               seg_q    <= seg_pick_n;
               dp_q     <= dp_pick_n;
            end else begin
               seg_q <= hold_seg;
               dp_q  <= hold_dp;
            end
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.dp         = dp_q;
   assign bus.digit_sel  = sel_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller
//   Directed bench for seg_scan_controller with DIV=8, BLANK=2.
//   Cycle numbers count posedges from reset release (or from the en
//   restart); outputs are sampled 2 time units after each posedge.
module tb_seg_scan_controller;
   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg_scan_if bus ();

   seg_scan_controller #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [6:0] exp_pat [4];
   logic [3:0] exp_dpm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, " an"},   32'(bus.an),         32'hF);
      chk({tag, " seg"},  32'(bus.seg),        32'h7F);
      chk({tag, " dp"},   32'(bus.dp),         32'h1);
      chk({tag, " sel"},  32'(bus.digit_sel),  32'h0);
      chk({tag, " tick"}, 32'(bus.frame_tick), 32'h0);
   endtask

   // Expected pins at cycle rel of an uninterrupted scan.
   task automatic chk_cycle(input int rel, input bit dark);
      int         pos, d;
      bit         lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_tick;
      logic [1:0] e_sel;
      string      tg;
      tg = $sformatf("c%0d", rel);
      if (dark) begin
         chk_dark(tg);
      end else begin
         pos    = rel % DIV;
         d      = (rel / DIV) % 4;
         lit    = (pos >= BLANK);
         e_an   = lit ? ~(4'b0001 << d) : 4'hF;
         e_seg  = lit ? exp_pat[d] : 7'h7F;
         e_dp   = (lit && exp_dpm[d]) ? 1'b0 : 1'b1;
         e_sel  = 2'(d);
         e_tick = (rel > 0) && (rel % (4 * DIV) == 0);
         chk({tg, " an"},   32'(bus.an),         32'(e_an));
         chk({tg, " seg"},  32'(bus.seg),        32'(e_seg));
         chk({tg, " dp"},   32'(bus.dp),         32'(e_dp));
         chk({tg, " sel"},  32'(bus.digit_sel),  32'(e_sel));
         chk({tg, " tick"}, 32'(bus.frame_tick), 32'(e_tick));
      end
      chk({tg, " onehot"}, 32'($countones(~bus.an) <= 1), 32'h1);
   endtask

   task automatic step(input int rel, input bit dark);
      @(posedge clk);
      #2;
      chk_cycle(rel, dark);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.seg0    = 7'h40;
      bus.seg1    = 7'h79;
      bus.seg2    = 7'h24;
      bus.seg3    = 7'h30;
      bus.dp_mask = 4'b0100;
      exp_pat[0]  = 7'h40;
      exp_pat[1]  = 7'h79;
      exp_pat[2]  = 7'h24;
      exp_pat[3]  = 7'h30;
      exp_dpm     = 4'b0100;

      repeat (2) @(posedge clk);
      #2;
      chk_dark("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Scan order, mid-slot pattern change, dp and frame ticks at 32/64/96.
      for (int c = 0; c <= 116; c++) begin
         step(c, 1'b0);
         if (c == 4) bus.seg0 = 7'h12;
         if (c == 8) exp_pat[0] = 7'h12;
      end

      // Cycle 116 is digit 2 SHOW: reset darkens within the same cycle.
      #1 rst_n = 1'b0;
      #1 chk_dark("midrst");
      bus.seg0   = 7'h40;
      exp_pat[0] = 7'h40;
      @(negedge clk);
      rst_n = 1'b1;

      // en drop during digit 2 SHOW and restart.
      for (int c = 0; c <= 30; c++) begin
         step(c, (c >= 20));
         if (c == 19) bus.en = 1'b0;
         if (c == 30) bus.en = 1'b1;
      end
      for (int c = 31; c <= 75; c++) step(c - 31, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
